spu_result_collector: RTL and testbench
=======================================

SPU_RESULT_COLLECTOR -- requirements
Module: spu_result_collector

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, width of each result lane.
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter type data_t, default signed [DATA_BITS-1:0], lane type.
REQ-004 SHALL have port clk, input, 1, clock; reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1, software run permission for the upstream pipeline.
REQ-006 SHALL have port cke, output, 1, clock enable driven to the upstream cke-gated calc pipeline.
REQ-007 SHALL have ports s_data0 and s_data1, input, data_t, upstream product and sum lanes.
REQ-008 SHALL have port s_valid, input, 1, upstream result valid.
REQ-009 SHALL have ports m_data0 and m_data1, output, data_t, buffered result lanes.
REQ-010 SHALL have ports m_valid, output, 1, and m_ready, input, 1, ready/valid output handshake.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1) bits, current buffer occupancy.
REQ-012 SHALL have port accepted, output, 32, total results captured since reset.

Function
REQ-013 SHALL capture {s_data0, s_data1} into the buffer at a rising edge iff s_valid=1 and cke=1 in that cycle; with cke=0 the held upstream output SHALL NOT be captured (no duplicates).
REQ-014 SHALL drive cke from a register; cke next = enable AND (occupancy after this edge < DEPTH).
REQ-015 SHALL pop the head entry at an edge where m_valid=1 and m_ready=1.
REQ-016 SHALL present the head entry on m_data0/m_data1 with m_valid=1 whenever occupancy > 0 (first-word fall-through); m_data* SHALL be don't-care when m_valid=0.
REQ-017 SHALL deliver entries strictly in capture order, lanes unmodified, no sign/width change.
REQ-018 SHALL have minimum latency of 1 cycle: a result captured at edge N appears on m_valid after edge N.
REQ-019 SHALL, on simultaneous capture and pop, keep occupancy unchanged and update both pointers.
REQ-020 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-021 SHALL never overflow: because cke=0 whenever full, a capture into a full buffer cannot occur; an assertion SHALL flag it.
REQ-022 SHALL, when full and popped with cke=0, raise cke at the next edge, one cycle of upstream stall.
REQ-023 SHALL increment accepted by 1 per capture, wrapping 2^32-1 -> 0.
REQ-024 SHALL, with enable=0, hold cke=0 from the next edge while still draining the buffer to m_*.

Reset
REQ-025 SHALL on reset set cke=0, m_valid=0, count=0, accepted=0, pointers=0; buffer contents not reset.
REQ-026 SHALL discard all buffered entries on reset asserted mid-operation; cke SHALL rise no earlier than the second edge after reset deasserts.

Structure
REQ-027 SHALL take DATA_BITS default and data_t from the shared spu package.
REQ-028 SHALL implement storage in one sub-module spu_fifo_fwft (DEPTH x 2*DATA_BITS distributed RAM, pointers, count); cke, enable gating and accepted counter remain in the top.

Verification
REQ-029 Reset, enable=1, m_ready=1, upstream computes 3*4 -> s_data0=12, s_data1=7 valid one cycle with cke=1 -> m_data0=12, m_data1=7, m_valid one cycle, accepted=1.
REQ-030 m_ready=0, continuous s_valid with values 1..10 -> exactly 8 captured, cke=0 from edge after count reaches 8, count=8; then m_ready=1 -> output 1..10 in order, none duplicated.
REQ-031 Full buffer, s_valid held high while cke=0 for 5 cycles -> count stays 8, accepted unchanged.
REQ-032 Half-full, capture and pop every cycle for 20 cycles -> count constant 4, pointers wrap, order preserved.
REQ-033 enable 1->0 with 3 entries buffered -> cke=0 next cycle, 3 entries drain, no new captures.
REQ-034 Reset asserted with 5 entries buffered -> m_valid=0, count=0 next cycle; post-reset data 7,9 emerge as first outputs.

Source files
------------

// File: rtl/spu_pkg.sv
// ============================================================================
// Module   : spu_pkg
// Purpose  : Shared SPU definitions. This package holds the default result-lane
//            width and the matching lane type used across the SPU datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spu_pkg;

    // Default width of one result lane (product or sum).
    localparam int SPU_DATA_BITS = 8;

    // Lane type at the default width. Parameterised modules rebuild the same
    // shape from their own DATA_BITS so that width overrides stay consistent.
    typedef logic signed [SPU_DATA_BITS-1:0] spu_data_t;

endpackage : spu_pkg

`default_nettype wire

// File: rtl/spu_fifo_fwft.sv
// ============================================================================
// Module   : spu_fifo_fwft
// Purpose  : First-word fall-through FIFO built on a small distributed RAM.
//            The head entry is read combinationally, so rd_data is valid
//            whenever empty=0.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            wr_en, wr_data        - push request and data (ignored when full)
//            rd_en, rd_data        - pop request and head data (ignored when empty)
//            empty, full, count    - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == '0);
    assign count   = occ;
    assign rd_data = mem[rd_ptr];

    // Storage is intentionally not reset; stale contents are unreachable
    // once the pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule : spu_fifo_fwft

`default_nettype wire

// File: rtl/spu_result_collector.sv
// ============================================================================
// Module   : spu_result_collector
// Purpose  : Collects {product, sum} results from a cke-gated upstream calc
//            pipeline into a FWFT buffer and presents them on a ready/valid
//            output. The upstream pipeline is stalled via cke so the buffer
//            can never overflow and a held result is never captured twice.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            enable                - software run permission for upstream
//            cke                   - registered clock enable to upstream
//            s_data0/1, s_valid    - upstream result lanes and valid
//            m_data0/1, m_valid,
//            m_ready               - buffered output handshake
//            count                 - buffer occupancy
//            accepted              - results captured since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_result_collector
    import spu_pkg::*;
#(
    parameter int  DATA_BITS = SPU_DATA_BITS,
    parameter int  DEPTH     = 8,
    parameter type data_t    = logic signed [DATA_BITS-1:0]
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    output logic                       cke,
    input  data_t                      s_data0,
    input  data_t                      s_data1,
    input  logic                       s_valid,
    output data_t                      m_data0,
    output data_t                      m_data1,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                accepted
);

    localparam int LW = $bits(data_t);
    localparam int CW = $clog2(DEPTH+1);

    logic            capture;
    logic            pop;
    logic            started;
    logic            cke_q;
    logic            empty;
    logic            full;
    logic [CW-1:0]   occ;
    logic [CW:0]     occ_next;
    logic [2*LW-1:0] wr_data;
    logic [2*LW-1:0] rd_data;

    // While cke=0 the upstream holds its last output; capturing only when
    // cke=1 means each upstream result is taken exactly once.
    assign capture  = s_valid & cke_q;
    assign pop      = m_valid & m_ready;
    assign occ_next = {1'b0, occ} + (CW+1)'(capture) - (CW+1)'(pop);

    assign wr_data  = {s_data0, s_data1};
    assign m_data0  = rd_data[2*LW-1:LW];
    assign m_data1  = rd_data[LW-1:0];
    assign m_valid  = ~empty;
    assign cke      = cke_q;
    assign count    = occ;

    spu_fifo_fwft #(
        .WIDTH (2*LW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (occ)
    );

    // started holds cke low for one extra edge after reset so the upstream
    // pipeline sees at least one full idle cycle before it may advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            started  <= 1'b0;
            cke_q    <= 1'b0;
            accepted <= '0;
        end else begin
            started  <= 1'b1;
            cke_q    <= started & enable & (occ_next < (CW+1)'(DEPTH));
            if (capture) begin
                accepted <= accepted + 32'd1;
            end
        end
    end

    // cke is derived from post-edge occupancy, so it is low whenever full.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                    !(capture && full));

endmodule : spu_result_collector

`default_nettype wire

// File: tb/tb_spu_result_collector.sv
// ============================================================================
// Module   : tb_spu_result_collector
// Purpose  : Self-checking bench for spu_result_collector: a vector table for
//            single-cycle behaviour followed by directed multi-cycle sequences
//            (fill/stall, steady-state wrap, enable drop, mid-run reset).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spu_result_collector;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              cke;
    logic signed [7:0] s_data0;
    logic signed [7:0] s_data1;
    logic              s_valid;
    logic signed [7:0] m_data0;
    logic signed [7:0] m_data1;
    logic              m_valid;
    logic              m_ready;
    logic [3:0]        count;
    logic [31:0]       accepted;

    int total;
    int bad;
    int exp_acc;
    int src_val;
    int src_step;
    int src_last;
    logic [15:0] exp_q[$];

    spu_result_collector #(
        .DATA_BITS (8),
        .DEPTH     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .cke      (cke),
        .s_data0  (s_data0),
        .s_data1  (s_data1),
        .s_valid  (s_valid),
        .m_data0  (m_data0),
        .m_data1  (m_data1),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .accepted (accepted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit en;
        bit sv;
        int d0;
        int d1;
        bit mr;
        bit e_mv;
        int e_m0;
        int e_m1;
        int e_cnt;
        bit e_cke;
        int e_acc;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(bit rst, bit en, bit sv, int d0, int d1, bit mr,
                                bit mv, int m0, int m1, int cnt, bit ck, int acc);
        vec_t v;
        v.rst = rst; v.en = en; v.sv = sv; v.d0 = d0; v.d1 = d1; v.mr = mr;
        v.e_mv = mv; v.e_m0 = m0; v.e_m1 = m1; v.e_cnt = cnt; v.e_cke = ck;
        v.e_acc = acc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        s_data0 = 8'(src_val);
        s_data1 = ~s_data0;
    endtask

    task automatic start_src(input int first, input int step, input int last);
        src_val  = first;
        src_step = step;
        src_last = last;
        drive_src();
        s_valid  = 1'b1;
    endtask

    // One clock with an upstream source that advances only on capture and a
    // scoreboard that checks every popped entry against capture order.
    task automatic tick();
        bit cap;
        bit pp;
        logic [15:0] head;
        cap = s_valid && cke && !reset;
        pp  = m_valid && m_ready && !reset;
        if (pp) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 1, 0);
            end else begin
                head = exp_q.pop_front();
                chk("out_data0", int'(m_data0), int'($signed(head[15:8])));
                chk("out_data1", int'(m_data1), int'($signed(head[7:0])));
            end
        end
        if (cap) begin
            exp_q.push_back({s_data0, s_data1});
            exp_acc++;
        end
        @(posedge clk);
        #1;
        if (cap) begin
            src_val += src_step;
            if (src_val > src_last) s_valid = 1'b0;
            drive_src();
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_acc = 0;
        reset   = 1'b1;
        enable  = 1'b1;
        s_valid = 1'b0;
        s_data0 = '0;
        s_data1 = '0;
        m_ready = 1'b1;

        //           rst en sv  d0    d1  mr   mv  m0    m1  cnt cke acc
        vecs[0]  = mk(1, 1, 0,   0,    0, 1,   0,   0,    0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0,   0,    0, 1,   0,   0,    0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0,   0,    0, 1,   0,   0,    0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 0,   0,    0, 1,   0,   0,    0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 1,  12,    7, 1,   1,  12,    7, 1, 1, 1);
        vecs[5]  = mk(0, 1, 0,   0,    0, 1,   0,   0,    0, 0, 1, 1);
        vecs[6]  = mk(0, 1, 1,  -3,    5, 0,   1,  -3,    5, 1, 1, 2);
        vecs[7]  = mk(0, 1, 1, 100, -128, 0,   1,  -3,    5, 2, 1, 3);
        vecs[8]  = mk(0, 1, 0,   0,    0, 1,   1, 100, -128, 1, 1, 3);
        vecs[9]  = mk(0, 1, 1,   1,    2, 1,   1,   1,    2, 1, 1, 4);
        vecs[10] = mk(0, 1, 0,   0,    0, 1,   0,   0,    0, 0, 1, 4);
        vecs[11] = mk(0, 0, 0,   0,    0, 1,   0,   0,    0, 0, 0, 4);
        vecs[12] = mk(0, 0, 1,   9,    9, 1,   0,   0,    0, 0, 0, 4);
        vecs[13] = mk(0, 1, 0,   0,    0, 1,   0,   0,    0, 0, 1, 4);

        for (int i = 0; i < 14; i++) begin
            reset   = vecs[i].rst;
            enable  = vecs[i].en;
            s_valid = vecs[i].sv;
            s_data0 = 8'(vecs[i].d0);
            s_data1 = 8'(vecs[i].d1);
            m_ready = vecs[i].mr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_m_valid", i), m_valid, vecs[i].e_mv);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d_cke", i), cke, vecs[i].e_cke);
            chk($sformatf("v%0d_accepted", i), accepted, vecs[i].e_acc);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d_m_data0", i), int'(m_data0), vecs[i].e_m0);
                chk($sformatf("v%0d_m_data1", i), int'(m_data1), vecs[i].e_m1);
            end
        end
        exp_acc = 4;
        s_valid = 1'b0;

        // Fill to full with the sink stalled, then hold for extra cycles.
        m_ready = 1'b0;
        start_src(1, 1, 10);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (count == 4'd8) chk("cke_low_when_full", cke, 0);
        end
        chk("full_count", count, 8);
        chk("full_accepted", accepted, 12);
        chk("full_cke", cke, 0);
        chk("source_held", s_valid, 1);

        // First pop from full re-opens cke on that same edge.
        m_ready = 1'b1;
        tick();
        chk("cke_after_full_pop", cke, 1);
        chk("count_after_full_pop", count, 7);
        for (int i = 0; i < 60; i++) begin
            if (!s_valid && exp_q.size() == 0) break;
            tick();
        end
        chk("drain_a_done", int'(!s_valid && exp_q.size() == 0), 1);
        chk("drain_a_accepted", accepted, 14);
        chk("drain_a_count", count, 0);
        chk("drain_a_no_extra", m_valid, 0);

        // Half-full steady state: capture and pop every cycle, pointers wrap.
        m_ready = 1'b0;
        start_src(20, 1, 1000);
        for (int i = 0; i < 10; i++) begin
            if (count == 4'd4) break;
            tick();
        end
        chk("half_fill", count, 4);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("steady_count", count, 4);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("steady_drained", exp_q.size(), 0);
        chk("steady_accepted", accepted, 38);

        // Drop enable with three entries buffered.
        m_ready = 1'b0;
        start_src(50, 1, 1000);
        for (int i = 0; i < 10; i++) begin
            if (count == 4'd3) break;
            tick();
        end
        chk("enable_fill", count, 3);
        s_valid = 1'b0;
        enable  = 1'b0;
        tick();
        chk("enable_off_cke", cke, 0);
        chk("enable_off_count", count, 3);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("enable_off_cke_hold", cke, 0);
        end
        chk("enable_off_drained", exp_q.size(), 0);
        chk("enable_off_count_end", count, 0);
        chk("enable_off_accepted", accepted, 41);

        // Reset with five entries buffered.
        enable  = 1'b1;
        m_ready = 1'b0;
        s_valid = 1'b0;
        tick();
        start_src(70, 1, 1000);
        for (int i = 0; i < 12; i++) begin
            if (count == 4'd5) break;
            tick();
        end
        chk("reset_fill", count, 5);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_m_valid", m_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_cke", cke, 0);
        chk("reset_accepted", accepted, 0);
        exp_q.delete();
        exp_acc = 0;
        reset   = 1'b0;
        m_ready = 1'b1;
        start_src(7, 2, 9);
        tick();
        chk("cke_first_edge_after_reset", cke, 0);
        for (int i = 0; i < 20; i++) begin
            if (!s_valid && exp_q.size() == 0) break;
            tick();
        end
        chk("post_reset_done", int'(!s_valid && exp_q.size() == 0), 1);
        chk("post_reset_accepted", accepted, 2);
        chk("post_reset_count", count, 0);
        chk("accepted_model", accepted, exp_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spu_result_collector

`default_nettype wire
